// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester handshakes and data-memory bus of dmem_arbiter.
// master = requesters plus memory model side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rd;
  logic              done0, done1, stall0, mem_memread, mem_memwrite;
  logic [2:0]        mem_f3;
  logic [63:0]       mem_addr;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    input  done0, done1, rdata, stall0, mem_memread, mem_memwrite, mem_f3, mem_addr, mem_wdata
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd,
    output done0, done1, rdata, stall0, mem_memread, mem_memwrite, mem_f3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter, one IDLE/ISSUE/RESP transaction per 3 cycles.
// DMEM_ARB_RR_EN selects round-robin tie-break; default is fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  state_e            state_q, state_d;
  logic              id_q, id_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win, latch, issue, resp;
  assign latch = (state_q == IDLE) && (bus.req0 || bus.req1);
`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;
  assign win    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign last_d = latch ? win : last_q;
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : last_d;
`else
  assign win = ~bus.req0;
`endif
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (latch) begin
        state_d = ISSUE;
        id_d    = win;
        we_d    = win ? bus.we1 : bus.we0;
        addr_d  = win ? bus.addr1 : bus.addr0;
        wdata_d = win ? bus.wdata1 : bus.wdata0;
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign issue            = (state_q == ISSUE);
  assign resp             = (state_q == RESP);
  assign bus.mem_memread  = issue && !we_q;
  assign bus.mem_memwrite = issue && we_q;
  assign bus.mem_addr     = issue ? 64'(addr_q) : 64'd0;
  assign bus.mem_wdata    = issue ? wdata_q : '0;
  assign bus.mem_f3       = 3'b011;
  assign bus.done0        = resp && !id_q;
  assign bus.done1        = resp && id_q;
  assign bus.rdata        = (resp && !we_q) ? bus.mem_rd : '0;
  assign bus.stall0       = bus.req0 && !bus.done0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus multi-cycle sequences against a registered-read memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int tests = 0;
  int fails = 0;
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(64)) bus ();
  dmem_arbiter #(.ADDR_W(10), .DATA_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 64'd0;
      bus.mem_rd <= 64'd0;
    end else begin
      if (bus.mem_memwrite) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      if (bus.mem_memread) bus.mem_rd <= mem[bus.mem_addr[9:0]];
    end
  end
  typedef struct {
    logic        port;
    logic        we;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } vec_t;
  vec_t vecs[9];
  logic exp_g[4];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    vec_t v;
    int n;
    vecs[0] = '{1'b1, 1'b1, 10'd5,    64'hDEADBEEF,         64'd0};
    vecs[1] = '{1'b0, 1'b0, 10'd5,    64'd0,                64'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 10'd1023, 64'hFFFFFFFFFFFFFFFF, 64'd0};
    vecs[3] = '{1'b1, 1'b0, 10'd1023, 64'd0,                64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{1'b1, 1'b0, 10'd0,    64'd0,                64'd0};
    vecs[5] = '{1'b0, 1'b1, 10'd0,    64'h0123456789ABCDEF, 64'd0};
    vecs[6] = '{1'b1, 1'b0, 10'd0,    64'd0,                64'h0123456789ABCDEF};
    vecs[7] = '{1'b1, 1'b1, 10'd9,    64'hA5A5A5A5A5A5A5A5, 64'd0};
    vecs[8] = '{1'b0, 1'b0, 10'd9,    64'd0,                64'hA5A5A5A5A5A5A5A5};
`ifdef DMEM_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    {bus.req0, bus.req1, bus.we0, bus.we1} = 4'b0;
    {bus.addr0, bus.addr1} = '0;
    {bus.wdata0, bus.wdata1} = '0;
    do_reset();
    mem_init = 1'b0;
    chk("rst_done0", bus.done0, 0);
    chk("rst_done1", bus.done1, 0);
    chk("rst_strobes", {bus.mem_memread, bus.mem_memwrite}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("f3", bus.mem_f3, 3'b011);
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      if (v.port) begin
        bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
      end else begin
        bus.req0 = 1'b1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
      end
      tick();
      chk($sformatf("v%0d_read", i), bus.mem_memread, !v.we);
      chk($sformatf("v%0d_write", i), bus.mem_memwrite, v.we);
      chk($sformatf("v%0d_addr", i), bus.mem_addr, 64'(v.addr));
      if (v.we) chk($sformatf("v%0d_wdata", i), bus.mem_wdata, v.wdata);
      chk($sformatf("v%0d_stall_issue", i), bus.stall0, !v.port);
      chk($sformatf("v%0d_done_early", i), {bus.done0, bus.done1}, 0);
      tick();
      chk($sformatf("v%0d_done0", i), bus.done0, !v.port);
      chk($sformatf("v%0d_done1", i), bus.done1, v.port);
      chk($sformatf("v%0d_rdata", i), bus.rdata, v.exp_rdata);
      chk($sformatf("v%0d_strobes_resp", i), {bus.mem_memread, bus.mem_memwrite}, 0);
      chk($sformatf("v%0d_stall_resp", i), bus.stall0, 0);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();
    end
    // store on port 1, then a load on port 0 raised in the store's done cycle
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 10'd7; bus.wdata1 = 64'h1122334455667788;
    tick();
    tick();
    chk("ls_done1", bus.done1, 1);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd7;
    #1;
    chk("ls_stall_c1", bus.stall0, 1);
    tick();
    chk("ls_stall_c2", bus.stall0, 1);
    tick();
    chk("ls_stall_c3", bus.stall0, 1);
    tick();
    chk("ls_stall_end", bus.stall0, 0);
    chk("ls_done0", bus.done0, 1);
    chk("ls_rdata", bus.rdata, 64'h1122334455667788);
    bus.req0 = 1'b0;
    tick();
    // both ports held for four transactions
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd5;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'd1023;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!(bus.done0 || bus.done1) && n < 8);
      chk($sformatf("tie%0d_cycles", t), n, (t == 0) ? 2 : 3);
      chk($sformatf("tie%0d_grant", t), {bus.done0, bus.done1}, exp_g[t] ? 2'b01 : 2'b10);
      chk($sformatf("tie%0d_rdata", t), bus.rdata, exp_g[t] ? 64'hFFFFFFFFFFFFFFFF : 64'hDEADBEEF);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    // port 0 served last, then reset in ISSUE must restore port 0 priority
    bus.req0 = 1'b1;
    tick();
    tick();
    chk("pre_done0", bus.done0, 1);
    bus.req0 = 1'b0;
    tick();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    chk("abort_issue_read", bus.mem_memread, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_done", {bus.done0, bus.done1}, 0);
    chk("abort_strobes", {bus.mem_memread, bus.mem_memwrite}, 0);
    tick();
    chk("abort_reissue_addr", bus.mem_addr, 64'd5);
    chk("abort_reissue_read", bus.mem_memread, 1);
    tick();
    chk("abort_tie_port0", {bus.done0, bus.done1}, 2'b10);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    // req0 withdrawn right after being latched
    bus.req0 = 1'b1; bus.addr0 = 10'd9;
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("drop_stall", bus.stall0, 0);
    tick();
    chk("drop_done0", bus.done0, 1);
    chk("drop_rdata", bus.rdata, 64'hA5A5A5A5A5A5A5A5);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n += int'(bus.done0) + int'(bus.done1) + int'(bus.mem_memread) + int'(bus.mem_memwrite);
    end
    chk("drop_no_second", n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
